hv_reg_acc_ctrl: RTL and testbench
==================================

Name: hv_reg_acc_ctrl

Overview:
Register-access responder at the slave end of the SPI/OWT arbiter's rac_* request interface. It accepts one write or read request at a time and checks the write CRC. Accepted writes are committed to the register bank through a simple strobe port. Read data is fetched from the bank and returned, and every request completes with a one-cycle wack or rack pulse.

Parameters:
REG_AW, 7, register address width
REG_DW, 8, register data width
REG_CRC_W, 8, write CRC width
REG_NUM, 96, number of implemented registers; valid addresses are 0..REG_NUM-1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_rac_wr_req  in  1  write request; level, held until o_rac_wack
i_rac_rd_req  in  1  read request; level, held until o_rac_rack
i_rac_addr  in  REG_AW  request address
i_rac_wdata  in  REG_DW  write data
i_rac_wcrc  in  REG_CRC_W  write CRC
o_rac_wack  out  1  write-done pulse
o_rac_rack  out  1  read-done pulse
o_rac_data  out  REG_DW  read data; valid with o_rac_rack, then held
o_rac_addr  out  REG_AW  address of the returned read; valid with o_rac_rack, then held
o_reg_wr_en  out  1  bank write strobe, one cycle
o_reg_rd_en  out  1  bank read strobe, one cycle
o_reg_addr  out  REG_AW  bank address
o_reg_wdata  out  REG_DW  bank write data
i_reg_rdata  in  REG_DW  bank read data; valid the cycle after o_reg_rd_en
o_crc_err  out  1  CRC-fail pulse, coincident with o_rac_wack
o_crc_err_cnt  out  8  saturating CRC-fail count

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, WR, RD, RD_CAP, ACK.
- IDLE, capture: a request is sampled at edge N. i_rac_addr, i_rac_wdata and i_rac_wcrc are latched at that edge. The design ignores input changes after edge N.
- IDLE, priority: if wr and rd are both high, write wins. A read still held high is serviced after the write's ack.
- Write timing:
  - Cycle N+1 (WR): o_reg_wr_en=1, provided CRC passes and addr<REG_NUM.
  - Cycle N+2 (ACK): o_rac_wack=1.
- Read timing:
  - Cycle N+1 (RD): o_reg_rd_en=1, provided addr<REG_NUM.
  - Cycle N+2 (RD_CAP): i_reg_rdata is captured.
  - Cycle N+3 (ACK): o_rac_rack=1, o_rac_data=captured data, o_rac_addr=latched address.
  - o_rac_data and o_rac_addr hold until the next rack.
- ACK always returns to IDLE. A request still high in the cycle after ack is a new transaction, so the next sample edge is N+3 for writes and N+4 for reads.
- o_reg_addr and o_reg_wdata are driven from the latches. They are stable from N+1 until the next capture.
- CRC rule: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR. It is computed MSB-first over the 16-bit word {1'b0, addr[6:0], wdata[7:0]}.
- CRC mismatch: no o_reg_wr_en. o_rac_wack still pulses, with o_crc_err=1 in the same cycle. o_crc_err_cnt increments and saturates at 0xFF.
- Reads carry no CRC check.
- Out-of-range address (addr>=REG_NUM):
  - Write: acked with no strobe and no crc_err, even if the CRC is bad.
  - Read: no o_reg_rd_en; acked with o_rac_data=0.
- Request dropped before ack: the transaction completes normally and the ack is still issued.
- Reset mid-transaction: everything clears immediately and no ack is issued. o_crc_err_cnt clears only on reset.

Optional Feature:
HV_RAC_CRC_CHK_EN.
- Defined: CRC check as described above.
- Undefined: i_rac_wcrc is ignored, every in-range write is committed, and o_crc_err and o_crc_err_cnt are tied 0.
- Latency is identical in both builds.

Test Plan:
1. Write addr=0x00, wdata=0x01, wcrc=0x07 → o_reg_wr_en at N+1 with o_reg_addr=0x00 and o_reg_wdata=0x01; o_rac_wack at N+2; o_crc_err=0.
2. Write addr=0x00, wdata=0x01, wcrc=0x00 → no o_reg_wr_en; o_rac_wack and o_crc_err at N+2; o_crc_err_cnt=1. With the macro undefined, the same stimulus gives the write and no error.
3. Read addr=0x05, i_reg_rdata=0xA5 at N+2 → o_reg_rd_en at N+1; o_rac_rack at N+3 with o_rac_data=0xA5 and o_rac_addr=0x05; both hold afterwards.
4. wr_req and rd_req high together at addr=0x10 with valid CRC → write strobe and wack first; the read is sampled the cycle after wack and rack follows 3 cycles later.
5. Write to addr=0x7F (>=REG_NUM) → no strobe, wack at N+2. Read of 0x7F → no rd_en, rack with data 0x00.
6. Assert i_rst_n=0 at N+1 of a write → o_reg_wr_en and all other outputs drop immediately; no wack follows. After 300 CRC failures, o_crc_err_cnt=0xFF.

Source files
------------

// File: rtl/hv_reg_acc_ctrl.sv
// hv_reg_acc_ctrl: rac_* register-access responder that commits writes and fetches reads.
// Build option HV_RAC_CRC_CHK_EN enables the CRC-8 check on write requests.
module hv_reg_acc_ctrl #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int REG_NUM   = 96
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rac_wr_req,
  input  logic                 i_rac_rd_req,
  input  logic [REG_AW-1:0]    i_rac_addr,
  input  logic [REG_DW-1:0]    i_rac_wdata,
  input  logic [REG_CRC_W-1:0] i_rac_wcrc,
  output logic                 o_rac_wack,
  output logic                 o_rac_rack,
  output logic [REG_DW-1:0]    o_rac_data,
  output logic [REG_AW-1:0]    o_rac_addr,
  output logic                 o_reg_wr_en,
  output logic                 o_reg_rd_en,
  output logic [REG_AW-1:0]    o_reg_addr,
  output logic [REG_DW-1:0]    o_reg_wdata,
  input  logic [REG_DW-1:0]    i_reg_rdata,
  output logic                 o_crc_err,
  output logic [7:0]           o_crc_err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [REG_AW:0] NUM_LIM = (REG_AW + 1)'(REG_NUM);

  state_t state_r;
  logic   crc_bad_r;
  logic   rd_ok_r;
  logic   in_range_s;
  logic   crc_bad_s;

  assign in_range_s = ({1'b0, i_rac_addr} < NUM_LIM);

`ifdef HV_RAC_CRC_CHK_EN
  localparam int CRC_DW = 1 + REG_AW + REG_DW;
  localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);

  // MSB-first CRC over {0, addr, wdata}; init 0, no reflection, no final XOR
  function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [CRC_DW-1:0] word);
    logic [REG_CRC_W-1:0] crc;
    logic                 fb;
    crc = {REG_CRC_W{1'b0}};
    for (int i = CRC_DW - 1; i >= 0; i--) begin
      fb  = crc[REG_CRC_W-1] ^ word[i];
      crc = {crc[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {REG_CRC_W{1'b0}});
    end
    return crc;
  endfunction

  // CRC verdict on the live request, consumed only at the capture edge
  always_comb begin
    crc_bad_s = (crc_calc({1'b0, i_rac_addr, i_rac_wdata}) != i_rac_wcrc);
  end
`else
  wire unused_wcrc = ^i_rac_wcrc;

  // Without the check every write is treated as CRC-clean
  always_comb begin
    crc_bad_s = 1'b0;
  end
`endif

  // Transaction FSM; every rac/bank output is a register of this block
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      crc_bad_r     <= 1'b0;
      rd_ok_r       <= 1'b0;
      o_rac_wack    <= 1'b0;
      o_rac_rack    <= 1'b0;
      o_rac_data    <= {REG_DW{1'b0}};
      o_rac_addr    <= {REG_AW{1'b0}};
      o_reg_wr_en   <= 1'b0;
      o_reg_rd_en   <= 1'b0;
      o_reg_addr    <= {REG_AW{1'b0}};
      o_reg_wdata   <= {REG_DW{1'b0}};
      o_crc_err     <= 1'b0;
      o_crc_err_cnt <= 8'h00;
    end else begin
      o_reg_wr_en <= 1'b0;
      o_reg_rd_en <= 1'b0;
      o_rac_wack  <= 1'b0;
      o_rac_rack  <= 1'b0;
      o_crc_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_rac_wr_req) begin
            state_r     <= WR;
            o_reg_addr  <= i_rac_addr;
            o_reg_wdata <= i_rac_wdata;
            o_reg_wr_en <= in_range_s & ~crc_bad_s;
            // Out-of-range writes never report a CRC error
            crc_bad_r   <= in_range_s & crc_bad_s;
          end else if (i_rac_rd_req) begin
            state_r     <= RD;
            o_reg_addr  <= i_rac_addr;
            o_reg_rd_en <= in_range_s;
            rd_ok_r     <= in_range_s;
          end else begin
            state_r <= IDLE;
          end
        end
        WR: begin
          state_r    <= ACK;
          o_rac_wack <= 1'b1;
          o_crc_err  <= crc_bad_r;
          if (crc_bad_r && (o_crc_err_cnt != 8'hFF)) begin
            o_crc_err_cnt <= o_crc_err_cnt + 8'h01;
          end else begin
            o_crc_err_cnt <= o_crc_err_cnt;
          end
        end
        RD: begin
          state_r <= RD_CAP;
        end
        RD_CAP: begin
          state_r    <= ACK;
          o_rac_rack <= 1'b1;
          o_rac_data <= rd_ok_r ? i_reg_rdata : {REG_DW{1'b0}};
          o_rac_addr <= o_reg_addr;
        end
        ACK: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_reg_acc_ctrl.sv
// Directed, table-driven bench for hv_reg_acc_ctrl; expectations follow HV_RAC_CRC_CHK_EN.
module tb_hv_reg_acc_ctrl;

`ifdef HV_RAC_CRC_CHK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, rd_req;
  logic [6:0] addr;
  logic [7:0] wdata, wcrc, rdata;
  logic       wack, rack, reg_wr_en, reg_rd_en, crc_err;
  logic [7:0] rac_data, reg_wdata, crc_err_cnt;
  logic [6:0] rac_addr, reg_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hv_reg_acc_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rac_wr_req  (wr_req),
    .i_rac_rd_req  (rd_req),
    .i_rac_addr    (addr),
    .i_rac_wdata   (wdata),
    .i_rac_wcrc    (wcrc),
    .o_rac_wack    (wack),
    .o_rac_rack    (rack),
    .o_rac_data    (rac_data),
    .o_rac_addr    (rac_addr),
    .o_reg_wr_en   (reg_wr_en),
    .o_reg_rd_en   (reg_rd_en),
    .o_reg_addr    (reg_addr),
    .o_reg_wdata   (reg_wdata),
    .i_reg_rdata   (rdata),
    .o_crc_err     (crc_err),
    .o_crc_err_cnt (crc_err_cnt)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] wcrc;
    logic [7:0] rdata;
    logic       exp_en;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    int         exp_cnt;
    logic [7:0] last_data;
    logic [6:0] last_addr;
    int         n_wack, n_err, n_wen;

    // wr rd addr wdata wcrc rdata exp_en exp_err exp_data
    vecs[0]  = '{1'b1, 1'b0, 7'h00, 8'h01, 8'h07, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 7'h00, 8'h01, 8'h00, 8'h00, ~CRC_ON, CRC_ON, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 7'h05, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 1'b0, 7'h10, 8'h5A, 8'hD6, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 7'h05, 8'h3C, 8'hF5, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 7'h5F, 8'h9A, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 7'h60, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 7'h7F, 8'hFF, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 7'h5F, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C};
    vecs[9]  = '{1'b0, 1'b1, 7'h60, 8'h00, 8'h00, 8'h77, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 7'h7F, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 7'h10, 8'h5A, 8'hD7, 8'h00, ~CRC_ON, CRC_ON, 8'h00};

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    addr = 7'h00; wdata = 8'h00; wcrc = 8'h00; rdata = 8'h00;
    exp_cnt = 0; last_data = 8'h00; last_addr = 7'h00;

    step(); step();
    chk("rst_outputs", {wack, rack, reg_wr_en, reg_rd_en, crc_err}, 5'b0);
    chk("rst_buses", {rac_data, rac_addr, reg_addr, reg_wdata, crc_err_cnt}, 38'h0);
    rst_n = 1'b1;
    step();
    chk("idle_outputs", {wack, rack, reg_wr_en, reg_rd_en, crc_err}, 5'b0);

    // Table: request held for the capture edge only, then dropped and inputs scrambled
    for (int k = 0; k < 12; k++) begin
      v = vecs[k];
      wr_req = v.wr; rd_req = v.rd; addr = v.addr; wdata = v.wdata; wcrc = v.wcrc;
      rdata = 8'hEE;
      step();
      chk("n1_wr_en", reg_wr_en, v.wr ? v.exp_en : 1'b0);
      chk("n1_rd_en", reg_rd_en, v.rd ? v.exp_en : 1'b0);
      chk("n1_reg_addr", reg_addr, v.addr);
      if (v.wr) chk("n1_reg_wdata", reg_wdata, v.wdata);
      chk("n1_acks", {wack, rack}, 2'b00);
      wr_req = 1'b0; rd_req = 1'b0;
      addr = ~v.addr; wdata = ~v.wdata; wcrc = ~v.wcrc;
      step();
      chk("n2_wack", wack, v.wr);
      chk("n2_crc_err", crc_err, v.wr ? v.exp_err : 1'b0);
      chk("n2_strobes", {reg_wr_en, reg_rd_en}, 2'b00);
      chk("n2_reg_addr", reg_addr, v.addr);
      if (v.wr && v.exp_err) exp_cnt++;
      chk("n2_err_cnt", crc_err_cnt, exp_cnt);
      if (v.rd) begin
        rdata = v.rdata;
        step();
        chk("n3_rack", rack, 1'b1);
        chk("n3_rac_data", rac_data, v.exp_data);
        chk("n3_rac_addr", rac_addr, v.addr);
        rdata = 8'hEE;
        last_data = v.exp_data; last_addr = v.addr;
        step();
        chk("n4_rack_off", rack, 1'b0);
        chk("n4_data_hold", rac_data, last_data);
        chk("n4_addr_hold", rac_addr, last_addr);
      end else begin
        step();
        chk("n3_wack_off", {wack, crc_err}, 2'b00);
        chk("n3_data_hold", rac_data, last_data);
      end
    end

    // Simultaneous write and read, both held: write first, read sampled right after ack
    wr_req = 1'b1; rd_req = 1'b1; addr = 7'h10; wdata = 8'h5A; wcrc = 8'hD6; rdata = 8'hEE;
    step();
    chk("both_wr_en", reg_wr_en, 1'b1);
    chk("both_no_rd_en", reg_rd_en, 1'b0);
    step();
    chk("both_wack", wack, 1'b1);
    chk("both_no_rack", rack, 1'b0);
    wr_req = 1'b0;
    step();
    chk("both_gap", {wack, reg_rd_en, reg_wr_en}, 3'b000);
    step();
    chk("both_rd_en", reg_rd_en, 1'b1);
    chk("both_rd_addr", reg_addr, 7'h10);
    step();
    chk("both_cap_no_rack", rack, 1'b0);
    rdata = 8'hC3;
    step();
    chk("both_rack", rack, 1'b1);
    chk("both_rac_data", rac_data, 8'hC3);
    chk("both_rac_addr", rac_addr, 7'h10);
    rd_req = 1'b0; rdata = 8'hEE;
    step();
    chk("both_done", {rack, reg_rd_en}, 2'b00);
    chk("both_data_hold", rac_data, 8'hC3);

    // Reset during the write strobe cycle: everything clears and no ack follows
    wr_req = 1'b1; addr = 7'h00; wdata = 8'h01; wcrc = 8'h07;
    step();
    chk("rstmid_wr_en", reg_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en_drop", reg_wr_en, 1'b0);
    chk("rstmid_buses", {rac_data, rac_addr, reg_addr, reg_wdata, crc_err_cnt}, 38'h0);
    wr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstmid_no_wack", wack, 1'b0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstmid_post_no_wack", {wack, crc_err}, 2'b00);
    end

    // 300 back-to-back CRC failures with the request held high
    wr_req = 1'b1; addr = 7'h00; wdata = 8'h01; wcrc = 8'h00;
    n_wack = 0; n_err = 0; n_wen = 0;
    for (int c = 0; c < 1000 && n_wack < 300; c++) begin
      step();
      n_wack += int'(wack);
      n_err  += int'(crc_err);
      n_wen  += int'(reg_wr_en);
    end
    wr_req = 1'b0;
    chk("sat_wack_count", n_wack, 300);
    chk("sat_err_count", n_err, CRC_ON ? 300 : 0);
    chk("sat_wen_count", n_wen, CRC_ON ? 0 : 300);
    step();
    chk("sat_err_cnt", crc_err_cnt, CRC_ON ? 8'hFF : 8'h00);
    step();
    chk("sat_idle", {wack, reg_wr_en}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
